// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and UART Tx signals for the shared-transmitter arbiter.
// The arbiter uses the slave modport. Requesters and the Tx use the master modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_byte;
    logic [NUM_REQ-1:0]   i_req_last;
    logic [NUM_REQ-1:0]   o_req_ready;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 o_busy;
    logic                 o_tx_dv;
    logic [7:0]           o_tx_byte;
    logic                 i_tx_active;
    logic                 i_tx_done;

    modport master (
        output i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
        input  o_req_ready, o_grant, o_busy, o_tx_dv, o_tx_byte
    );

    modport slave (
        input  i_req_valid, i_req_byte, i_req_last, i_tx_active, i_tx_done,
        output o_req_ready, o_grant, o_busy, o_tx_dv, o_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte streams.
// Ownership lasts for a whole message. It is released after the byte flagged last completes,
// or when the owner stalls between bytes for GAP_TIMEOUT clocks.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [PTR_W-1:0]   gnt_idx_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               last_r;
    logic               done_d_r;
    logic               busy_r;
    logic               tx_dv_r;
    logic [7:0]         tx_byte_r;

    logic               pick_vld_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic [PTR_W-1:0]   cand_s;
    logic [7:0]         sel_byte_s;
    logic               sel_last_s;
    logic [NUM_REQ-1:0] ready_s;
    logic               xfer_s;
    logic               done_rise_s;

    // Convert a requester index to its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
        return oh;
    endfunction

    // Round-robin search: first valid requester after the last owner.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = {PTR_W{1'b0}};
        cand_s     = {PTR_W{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = PTR_W'((int'(rr_ptr_r) + i) % NUM_REQ);
            if (!pick_vld_s && bus.i_req_valid[cand_s]) begin
                pick_vld_s = 1'b1;
                pick_idx_s = cand_s;
            end else begin
                pick_vld_s = pick_vld_s;
                pick_idx_s = pick_idx_s;
            end
        end
    end

    // Byte and last flag presented by the current owner.
    always_comb begin
        sel_byte_s = bus.i_req_byte[int'(gnt_idx_r)*8 +: 8];
        sel_last_s = bus.i_req_last[gnt_idx_r];
    end

    // Only the owner can be accepted, and only while waiting for its next byte.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        if (rst_n && (state_r == ST_LOAD)) begin
            ready_s = bus.i_req_valid & grant_r;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    assign xfer_s      = |ready_s;
    assign done_rise_s = bus.i_tx_done & ~done_d_r;

    assign bus.o_req_ready = ready_s;
    assign bus.o_grant     = grant_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_tx_dv     = tx_dv_r;
    assign bus.o_tx_byte   = tx_byte_r;

    // Arbitration FSM: grant, byte handoff to the Tx, and completion tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= {NUM_REQ{1'b0}};
            gnt_idx_r <= {PTR_W{1'b0}};
            rr_ptr_r  <= PTR_INIT;
            gap_cnt_r <= {GAP_W{1'b0}};
            last_r    <= 1'b0;
            done_d_r  <= 1'b0;
            busy_r    <= 1'b0;
            tx_dv_r   <= 1'b0;
            tx_byte_r <= 8'h00;
        end else begin
            // Done is edge-detected so a level held from an earlier byte is not counted again.
            done_d_r <= bus.i_tx_done;
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        grant_r   <= idx_to_onehot(pick_idx_s);
                        gnt_idx_r <= pick_idx_s;
                        gap_cnt_r <= {GAP_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        tx_byte_r <= sel_byte_s;
                        last_r    <= sel_last_s;
                        gap_cnt_r <= {GAP_W{1'b0}};
                        tx_dv_r   <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else if (gap_cnt_r == GAP_LAST) begin
                        // Owner stalled too long: truncate its message and rearbitrate.
                        grant_r   <= {NUM_REQ{1'b0}};
                        rr_ptr_r  <= gnt_idx_r;
                        gap_cnt_r <= {GAP_W{1'b0}};
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                ST_ISSUE: begin
                    // Data-valid is level-held until the Tx reports it has started.
                    if (bus.i_tx_active) begin
                        tx_dv_r <= 1'b0;
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_rise_s) begin
                        if (last_r) begin
                            rr_ptr_r <= gnt_idx_r;
                            grant_r  <= {NUM_REQ{1'b0}};
                            busy_r   <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    grant_r <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    tx_dv_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. It uses per-requester byte queues and a small UART Tx model.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int GAP_TIMEOUT = 16;
    localparam int TX_BITS     = 8;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bif ();

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GAP_TIMEOUT (GAP_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int          n_vec    = 0;
    int          n_err    = 0;
    int          done_len = 2;
    logic [8:0]  rq_q [NUM_REQ][$];   // {last, byte} per requester
    logic [11:0] sb_q [$];            // {expected one-hot owner, byte}

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never settles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int k, input logic [7:0] b, input logic l);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        rq_q[k].push_back({l, b});
        sb_q.push_back({oh, b});
    endtask

    // which: 0 = tx_done high, 1 = tx_active high, other = grant equals val
    task automatic wait_for(input string tag, input int which, input logic [3:0] val, input int budget);
        int cyc;
        bit hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < budget) begin
            tick();
            cyc++;
            case (which)
                0:       hit = bif.i_tx_done;
                1:       hit = bif.i_tx_active;
                default: hit = (bif.o_grant == val);
            endcase
        end
        if (!hit) check_eq({tag, "_timeout"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int cyc;
        int pend;
        cyc = 0;
        while ((sb_q.size() != 0 || bif.o_busy || bif.i_tx_active || bif.i_tx_done) && cyc < budget) begin
            tick();
            cyc++;
        end
        if (cyc >= budget)
            check_eq({tag, "_timeout"}, {28'd0, bif.o_busy, bif.i_tx_active, bif.i_tx_done, sb_q.size() != 0}, 32'd0);
        pend = 0;
        for (int k = 0; k < NUM_REQ; k++) pend += rq_q[k].size();
        check_eq({tag, "_pending"}, 32'(pend), 32'd0);
        check_eq({tag, "_grant_idle"}, {28'd0, bif.o_grant}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requesters: present the queue head, hold it until accepted.
    initial begin
        logic [NUM_REQ-1:0] take;
        bif.i_req_valid = '0;
        bif.i_req_byte  = '0;
        bif.i_req_last  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (rq_q[k].size() > 0) begin
                    bif.i_req_valid[k]        = 1'b1;
                    bif.i_req_byte[8*k +: 8]  = rq_q[k][0][7:0];
                    bif.i_req_last[k]         = rq_q[k][0][8];
                end else begin
                    bif.i_req_valid[k] = 1'b0;
                    bif.i_req_last[k]  = 1'b0;
                end
            end
            #4;
            take = bif.i_req_valid & bif.o_req_ready;
            @(posedge clk);
            for (int k = 0; k < NUM_REQ; k++)
                if (take[k] && rq_q[k].size() > 0) void'(rq_q[k].pop_front());
        end
    end

    // UART Tx model: accept dv when idle, stay active TX_BITS clks, then done for done_len clks.
    initial begin
        int bit_cnt;
        int done_cnt;
        logic [11:0] exp_e;
        bit_cnt  = 0;
        done_cnt = 0;
        bif.i_tx_active = 1'b0;
        bif.i_tx_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bif.i_tx_active = 1'b0;
                bif.i_tx_done   = 1'b0;
                bit_cnt  = 0;
                done_cnt = 0;
            end else begin
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) bif.i_tx_done = 1'b0;
                end
                if (bif.i_tx_active) begin
                    bit_cnt--;
                    if (bit_cnt == 0) begin
                        bif.i_tx_active = 1'b0;
                        bif.i_tx_done   = 1'b1;
                        done_cnt        = done_len;
                    end
                end else if (bif.o_tx_dv) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        exp_e = sb_q.pop_front();
                        check_eq("tx_byte", {24'd0, bif.o_tx_byte}, {24'd0, exp_e[7:0]});
                        check_eq("tx_owner", {28'd0, bif.o_grant}, {28'd0, exp_e[11:8]});
                    end
                    bif.i_tx_active = 1'b1;
                    bit_cnt         = TX_BITS;
                end
            end
        end
    end

    // Scenario sequence.
    initial begin
        int  cyc;
        bit  hit;
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_grant", {28'd0, bif.o_grant}, 32'd0);
        check_eq("rst_busy", {31'd0, bif.o_busy}, 32'd0);
        check_eq("rst_dv", {31'd0, bif.o_tx_dv}, 32'd0);
        check_eq("rst_byte", {24'd0, bif.o_tx_byte}, 32'd0);
        check_eq("rst_ready", {28'd0, bif.o_req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte from req0, dv one clock after the transfer.
        send(0, 8'hA5, 1'b1);
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 20) begin
            @(negedge clk);
            #4;
            hit = bif.o_req_ready[0] & bif.i_req_valid[0];
            cyc++;
        end
        if (!hit) check_eq("s1_accept_timeout", {31'd0, hit}, 32'd1);
        tick();
        check_eq("s1_dv", {31'd0, bif.o_tx_dv}, 32'd1);
        check_eq("s1_byte", {24'd0, bif.o_tx_byte}, 32'h0000_00A5);
        check_eq("s1_grant", {28'd0, bif.o_grant}, 32'h1);
        check_eq("s1_busy", {31'd0, bif.o_busy}, 32'd1);
        wait_drain("s1", 100);

        // req1 and req2 together with rr_ptr reset to 3.
        do_reset();
        send(1, 8'h31, 1'b1);
        send(2, 8'h52, 1'b1);
        wait_for("s2_done", 0, 4'h0, 60);
        tick();
        check_eq("s2_gap_grant", {28'd0, bif.o_grant}, 32'd0);
        check_eq("s2_gap_busy", {31'd0, bif.o_busy}, 32'd0);
        tick();
        check_eq("s2_regrant", {28'd0, bif.o_grant}, 32'h4);
        wait_drain("s2", 100);

        // req0 three-byte message while req3 waits.
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        wait_for("s3_grant0", 2, 4'h1, 20);
        send(3, 8'h3D, 1'b1);
        @(negedge clk);
        #4;
        check_eq("s3_req3_blocked", {31'd0, bif.o_req_ready[3]}, 32'd0);
        wait_drain("s3", 200);

        // req2 sends one non-final byte then stalls until the grant is revoked.
        send(2, 8'h42, 1'b0);
        wait_for("s4_done", 0, 4'h0, 60);
        repeat (GAP_TIMEOUT) tick();
        check_eq("s4_hold_grant", {28'd0, bif.o_grant}, 32'h4);
        tick();
        check_eq("s4_revoke_grant", {28'd0, bif.o_grant}, 32'd0);
        check_eq("s4_revoke_busy", {31'd0, bif.o_busy}, 32'd0);
        send(2, 8'h77, 1'b1);
        wait_drain("s4", 100);

        // Done level outlasts the next byte's start and must not be counted twice.
        done_len = 6;
        send(1, 8'hC3, 1'b0);
        send(1, 8'h3C, 1'b1);
        wait_drain("s5", 200);
        done_len = 2;

        // Reset during WAIT_DONE aborts the message.
        send(0, 8'hE1, 1'b0);
        send(0, 8'hE2, 1'b1);
        wait_for("s6_active", 1, 4'h0, 30);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        rq_q[0].delete();
        sb_q.delete();
        tick();
        check_eq("s6_rst_grant", {28'd0, bif.o_grant}, 32'd0);
        check_eq("s6_rst_busy", {31'd0, bif.o_busy}, 32'd0);
        check_eq("s6_rst_dv", {31'd0, bif.o_tx_dv}, 32'd0);
        check_eq("s6_rst_byte", {24'd0, bif.o_tx_byte}, 32'd0);
        check_eq("s6_rst_ready", {28'd0, bif.o_req_ready}, 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'h5A, 1'b1);
        wait_for("s6_regrant", 2, 4'h1, 20);
        wait_drain("s6", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
